multi_clk_gen: RTL and testbench

//   Synthesisable, multi-channel successor to the simulation-only clock generator.

---
 rtl/multi_clk_gen_pkg.sv | 16 +
 rtl/multi_clk_gen_ch.sv | 86 ++++++++
 rtl/multi_clk_gen.sv | 64 ++++++
 tb/tb_multi_clk_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_clk_gen_pkg.sv
// rtl/multi_clk_gen_pkg.sv - shared config type and validation for multi_clk_gen
package multi_clk_gen_pkg;

  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] period;
    logic [DEF_CNT_W-1:0] high;
    logic [DEF_CNT_W-1:0] phase;
  } clk_cfg_t;

  function automatic logic cfg_valid(input clk_cfg_t c);
    return (c.period >= DEF_CNT_W'(2)) && (c.high <= c.period) && (c.phase < c.period);
  endfunction

endpackage

// File: rtl/multi_clk_gen_ch.sv
// rtl/multi_clk_gen_ch.sv - one divider channel: active/shadow config, counter, output flops
module multi_clk_gen_ch
  import multi_clk_gen_pkg::*;
#(
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     we,
  input  logic     sync,
  input  clk_cfg_t wcfg,
  output logic     clk_out,
  output logic     tick,
  output logic     pend
);

  localparam int W = DEF_CNT_W;

  clk_cfg_t       act_q, act_d, shd_q, shd_d;
  logic           run_q, run_d, pend_q, pend_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           clk_d, tick_d;

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    run_d  = run_q;
    cnt_d  = cnt_q;
    if (!en) begin
      // Disable edge: a direct write wins, otherwise a pending shadow is flushed.
      run_d  = 1'b0;
      cnt_d  = '0;
      pend_d = 1'b0;
      if (we)          act_d = wcfg;
      else if (pend_q) act_d = shd_q;
    end else if (!run_q || sync) begin
      run_d  = 1'b1;
      pend_d = 1'b0;
      if (we)          act_d = wcfg;
      else if (pend_q) act_d = shd_q;
      cnt_d  = act_d.phase;
    end else begin
      if (we) begin
        shd_d  = wcfg;
        pend_d = 1'b1;
      end
      if (cnt_q >= act_q.period - W'(1)) begin
        cnt_d = '0;
        if (pend_d) begin
          act_d  = shd_d;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
    clk_d  = en && (cnt_d < act_d.high);
    tick_d = en && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q   <= '{period: W'(DEF_PERIOD), high: W'(DEF_HIGH), phase: '0};
      shd_q   <= '{period: W'(DEF_PERIOD), high: W'(DEF_HIGH), phase: '0};
      run_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      act_q   <= act_d;
      shd_q   <= shd_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      clk_out <= clk_d;
      tick    <= tick_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/multi_clk_gen.sv
// rtl/multi_clk_gen.sv - multi-channel programmable clock-enable generator (top)
module multi_clk_gen
  import multi_clk_gen_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [CNT_W-1:0]  CFG_PERIOD,
  input  logic [CNT_W-1:0]  CFG_HIGH,
  input  logic [CNT_W-1:0]  CFG_PHASE,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              SYNC,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] CFG_PEND,
  output logic              CFG_ERR
);

  clk_cfg_t wcfg;
  logic     ch_ok, legal;

  assign wcfg.period = CFG_PERIOD;
  assign wcfg.high   = CFG_HIGH;
  assign wcfg.phase  = CFG_PHASE;

  // Only a non-power-of-two channel count can address a missing channel.
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = ({1'b0, CFG_CH} < (CH_W + 1)'(NUM_CH));
  end

  assign legal = cfg_valid(wcfg) && ch_ok;

  always_ff @(posedge CLK) begin
    if (RST) CFG_ERR <= 1'b0;
    else     CFG_ERR <= CFG_WE && !legal;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_clk_gen_ch #(
      .DEF_PERIOD(DEF_PERIOD),
      .DEF_HIGH  (DEF_HIGH)
    ) u_ch (
      .clk    (CLK),
      .rst    (RST),
      .en     (CH_EN[i]),
      .we     (CFG_WE && legal && (CFG_CH == CH_W'(i))),
      .sync   (SYNC),
      .wcfg   (wcfg),
      .clk_out(CLK_OUT[i]),
      .tick   (TICK[i]),
      .pend   (CFG_PEND[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_gen.sv
// tb/tb_multi_clk_gen.sv - self-checking bench for multi_clk_gen
module tb_multi_clk_gen;

  localparam int N = 4;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST, CFG_WE, SYNC;
  logic [1:0]   CFG_CH;
  logic [W-1:0] CFG_PERIOD, CFG_HIGH, CFG_PHASE;
  logic [N-1:0] CH_EN;
  logic [N-1:0] CLK_OUT, TICK, CFG_PEND;
  logic         CFG_ERR;

  logic         cfg_we3;
  logic [1:0]   cfg_ch3;
  logic [2:0]   clk_out3, tick3, pend3;
  logic         cfg_err3;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  multi_clk_gen dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
    .CFG_PERIOD(CFG_PERIOD), .CFG_HIGH(CFG_HIGH), .CFG_PHASE(CFG_PHASE),
    .CH_EN(CH_EN), .SYNC(SYNC), .CLK_OUT(CLK_OUT), .TICK(TICK),
    .CFG_PEND(CFG_PEND), .CFG_ERR(CFG_ERR)
  );

  multi_clk_gen #(.NUM_CH(3)) dut3 (
    .CLK(CLK), .RST(RST), .CFG_WE(cfg_we3), .CFG_CH(cfg_ch3),
    .CFG_PERIOD(CFG_PERIOD), .CFG_HIGH(CFG_HIGH), .CFG_PHASE(CFG_PHASE),
    .CH_EN(3'b000), .SYNC(SYNC), .CLK_OUT(clk_out3), .TICK(tick3),
    .CFG_PEND(pend3), .CFG_ERR(cfg_err3)
  );

  // Reference model: position within the period plus active/shadow settings.
  int m_p[N], m_h[N], m_f[N], s_p[N], s_h[N], s_f[N], m_pos[N];
  bit m_pend[N], m_run[N];
  logic [N-1:0] e_clk, e_tick, e_pend;
  logic e_err, e_err3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit fields_ok, legal, w;
    fields_ok = (CFG_PERIOD >= 2) && (CFG_HIGH <= CFG_PERIOD) && (CFG_PHASE < CFG_PERIOD);
    legal = CFG_WE && fields_ok && (int'(CFG_CH) < N);
    if (RST) begin
      for (int c = 0; c < N; c++) begin
        m_p[c] = 4; m_h[c] = 2; m_f[c] = 0; m_pos[c] = 0; m_pend[c] = 0; m_run[c] = 0;
      end
      e_clk = '0; e_tick = '0; e_pend = '0; e_err = 1'b0; e_err3 = 1'b0;
      return;
    end
    e_err  = CFG_WE && !legal;
    e_err3 = cfg_we3 && !(fields_ok && (int'(cfg_ch3) < 3));
    for (int c = 0; c < N; c++) begin
      w = legal && (int'(CFG_CH) == c);
      if (!CH_EN[c] || !m_run[c] || SYNC) begin
        if (w) begin
          m_p[c] = int'(CFG_PERIOD); m_h[c] = int'(CFG_HIGH); m_f[c] = int'(CFG_PHASE);
        end else if (m_pend[c]) begin
          m_p[c] = s_p[c]; m_h[c] = s_h[c]; m_f[c] = s_f[c];
        end
        m_pend[c] = 0;
        m_run[c]  = CH_EN[c];
        m_pos[c]  = CH_EN[c] ? m_f[c] : 0;
      end else begin
        if (w) begin
          s_p[c] = int'(CFG_PERIOD); s_h[c] = int'(CFG_HIGH); s_f[c] = int'(CFG_PHASE);
          m_pend[c] = 1;
        end
        m_pos[c] = (m_pos[c] + 1) % m_p[c];
        if (m_pos[c] == 0 && m_pend[c]) begin
          m_p[c] = s_p[c]; m_h[c] = s_h[c]; m_f[c] = s_f[c];
          m_pend[c] = 0;
        end
      end
      e_clk[c]  = CH_EN[c] && (m_pos[c] < m_h[c]);
      e_tick[c] = CH_EN[c] && (m_pos[c] == 0);
      e_pend[c] = m_pend[c];
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("clk_out", 32'(CLK_OUT), 32'(e_clk));
    check("tick", 32'(TICK), 32'(e_tick));
    check("cfg_pend", 32'(CFG_PEND), 32'(e_pend));
    check("cfg_err", 32'(CFG_ERR), 32'(e_err));
    check("cfg_err3", 32'(cfg_err3), 32'(e_err3));
  endtask

  task automatic wr(input int ch, input int p, input int h, input int f);
    CFG_WE = 1'b1; CFG_CH = 2'(ch);
    CFG_PERIOD = W'(p); CFG_HIGH = W'(h); CFG_PHASE = W'(f);
    step();
    CFG_WE = 1'b0;
  endtask

  logic [15:0] pa, pb, pc, pd;
  int ta, tb;

  initial begin
    RST = 1'b1; CFG_WE = 1'b0; CFG_CH = '0; SYNC = 1'b0; CH_EN = '0;
    CFG_PERIOD = '0; CFG_HIGH = '0; CFG_PHASE = '0; cfg_we3 = 1'b0; cfg_ch3 = '0;
    step(); step();
    check("reset_outputs", 32'({CLK_OUT, TICK, CFG_PEND, CFG_ERR}), 32'd0);

    // Defaults on ch0
    RST = 1'b0; CH_EN = 4'b0001; pa = '0; pb = '0; pc = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      pa = {pa[14:0], CLK_OUT[0]}; pb = {pb[14:0], TICK[0]};
      pc = pc | 16'({CLK_OUT[3:1], TICK[3:1]});
    end
    check("t1_clk0", 32'(pa), 32'h00CC);
    check("t1_tick0", 32'(pb), 32'h0088);
    check("t1_others_quiet", 32'(pc), 32'd0);

    // Idle write then enable ch1
    wr(1, 5, 2, 0);
    check("t2_idle_no_pend", 32'(CFG_PEND[1]), 32'd0);
    CH_EN = 4'b0011; pa = '0; pb = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      pa = {pa[14:0], CLK_OUT[1]}; pb = {pb[14:0], TICK[1]};
    end
    check("t2_clk1", 32'(pa), 32'b1100011000);
    check("t2_tick1", 32'(pb), 32'b1000010000);

    // Mid-period write to running ch1
    step();
    wr(1, 3, 1, 0);
    check("t3_pend_set", 32'(CFG_PEND[1]), 32'd1);
    pa = '0;
    for (int i = 0; i < 9; i++) begin
      step();
      pa = {pa[14:0], CLK_OUT[1]};
    end
    check("t3_clk1", 32'(pa), 32'b000100100);
    check("t3_pend_clear", 32'(CFG_PEND[1]), 32'd0);

    // Illegal writes
    wr(1, 1, 0, 0);
    check("t4_p1_err", 32'(CFG_ERR), 32'd1);
    wr(1, 5, 6, 0);
    check("t4_h_gt_p_err", 32'(CFG_ERR), 32'd1);
    wr(1, 5, 2, 5);
    check("t4_f_eq_p_err", 32'(CFG_ERR), 32'd1);
    check("t4_pend_unchanged", 32'(CFG_PEND[1]), 32'd0);
    step();
    check("t4_err_one_pulse", 32'(CFG_ERR), 32'd0);
    CFG_PERIOD = 16'd5; CFG_HIGH = 16'd2; CFG_PHASE = 16'd0;
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3;
    step();
    check("t4_ch_range_err", 32'(cfg_err3), 32'd1);
    cfg_ch3 = 2'd2;
    step();
    check("t4_ch_ok_no_err", 32'(cfg_err3), 32'd0);
    cfg_we3 = 1'b0;

    // SYNC aligns ch0 and ch2 in antiphase
    wr(0, 4, 2, 0);
    wr(2, 4, 2, 2);
    CH_EN = 4'b0111;
    step(); step(); step();
    SYNC = 1'b1; pa = '0; pb = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      SYNC = 1'b0;
      if (i == 0) begin
        check("t5_tick0_after_sync", 32'(TICK[0]), 32'd1);
        check("t5_pend0_cleared", 32'(CFG_PEND[0]), 32'd0);
      end
      pa = {pa[14:0], CLK_OUT[0]}; pb = {pb[14:0], CLK_OUT[2]};
    end
    check("t5_clk0", 32'(pa), 32'h00CC);
    check("t5_clk2", 32'(pb), 32'h0033);

    // H==0 and H==P extremes
    wr(3, 3, 0, 0);
    wr(1, 3, 3, 0);
    CH_EN = 4'b1111;
    step(); step(); step();
    pc = '0; pd = 16'hFFFF; ta = 0; tb = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      pc = pc | 16'(CLK_OUT[3]); pd = pd & 16'(CLK_OUT[1]);
      ta += int'(TICK[3]); tb += int'(TICK[1]);
    end
    check("t6_h0_const0", 32'(pc), 32'd0);
    check("t6_hp_const1", 32'(pd), 32'd1);
    check("t6_h0_ticks", 32'(ta), 32'd3);
    check("t6_hp_ticks", 32'(tb), 32'd3);

    // Reset mid-run restores defaults
    RST = 1'b1;
    step();
    check("t6_rst_outputs", 32'({CLK_OUT, TICK, CFG_PEND, CFG_ERR}), 32'd0);
    RST = 1'b0; CH_EN = 4'b0011; pa = '0; pb = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      pa = {pa[14:0], CLK_OUT[0]}; pb = {pb[14:0], CLK_OUT[1]};
    end
    check("t6_defaults_ch0", 32'(pa), 32'h00CC);
    check("t6_defaults_ch1", 32'(pb), 32'h00CC);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      CFG_WE     = ($urandom % 4) == 0;
      CFG_CH     = 2'($urandom);
      CFG_PERIOD = W'($urandom % 8);
      CFG_HIGH   = W'($urandom % 9);
      CFG_PHASE  = W'($urandom % 8);
      SYNC       = ($urandom % 16) == 0;
      cfg_we3    = ($urandom % 8) == 0;
      cfg_ch3    = 2'($urandom);
      if (($urandom % 10) == 0) CH_EN = N'($urandom);
      RST        = ($urandom % 250) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
